// File: rtl/mac_arbiter.sv
// Round-robin arbiter granting FIR channels bursts on one shared multiply-dequantise unit.
// Latency: a beat presented while granted appears on prod_out two cycles later (two register stages).
// Backpressure: requester stalls by dropping req while holding the grant; bursts end on last or MAX_BEATS.
module mac_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10,
  parameter int MAX_BEATS  = 32,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   last,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   a_in,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   b_in,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [DATA_WIDTH-1:0]                prod_out,
  output logic                                 prod_valid,
  output logic [ID_W-1:0]                      prod_id,
  output logic                                 prod_last,
  output logic                                 busy,
  output logic                                 overrun
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                         state;
  logic [ID_W-1:0]                ptr;
  logic [ID_W-1:0]                owner;
  logic [ID_W-1:0]                pick;
  logic [CNT_W-1:0]               beat_cnt;
  logic                           accept;
  logic                           burst_end;
  logic [DATA_WIDTH-1:0]          a_sel;
  logic [DATA_WIDTH-1:0]          b_sel;

  logic                           s1_vld;
  logic signed [2*DATA_WIDTH-1:0] s1_prod;
  logic [ID_W-1:0]                s1_id;
  logic                           s1_last;
  logic signed [2*DATA_WIDTH-1:0] shifted;

  // Pick the first requester at or after ptr, wrapping; scanning downward lets the smallest offset win.
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) pick = ID_W'((int'(ptr) + i) % NUM_REQ);
    end
  end

  assign accept    = (state == BURST) && req[owner];
  assign burst_end = accept && (last[owner] || (beat_cnt == CNT_W'(MAX_BEATS - 1)));
  assign a_sel     = a_in[owner];
  assign b_sel     = b_in[owner];
  assign shifted   = s1_prod >>> QUANT_BITS;
  assign busy      = (state == BURST) || s1_vld || prod_valid;

  // Burst FSM: grant in IDLE, count beats in BURST, release and advance the pointer on burst end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= pick;
            gnt   <= NUM_REQ'(1) << pick;
            state <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
            beat_cnt <= '0;
            if (!last[owner]) overrun <= 1'b1;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: full-width signed product of the accepted beat, tagged with owner and end-of-burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_prod <= '0;
      s1_id   <= '0;
      s1_last <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_prod <= $signed({{DATA_WIDTH{a_sel[DATA_WIDTH-1]}}, a_sel}) *
                   $signed({{DATA_WIDTH{b_sel[DATA_WIDTH-1]}}, b_sel});
        s1_id   <= owner;
        s1_last <= burst_end;
      end
    end
  end

  // Stage 2: dequantise (arithmetic shift, truncate); payload holds while no product is valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod_valid <= 1'b0;
      prod_out   <= '0;
      prod_id    <= '0;
      prod_last  <= 1'b0;
    end else begin
      prod_valid <= s1_vld;
      if (s1_vld) begin
        prod_out  <= shifted[DATA_WIDTH-1:0];
        prod_id   <= s1_id;
        prod_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// Self-checking bench for mac_arbiter: directed vector table, corner-case sequences, random vs. model.
// Timing: inputs change 1ns after the rising edge, outputs are checked at that same point.
// Reset is applied asynchronously mid-cycle and checked before the next edge.
module tb_mac_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int Q = 10;
  localparam int MAXB = 32;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0]      last;
  logic [N-1:0][W-1:0] a_in;
  logic [N-1:0][W-1:0] b_in;
  logic [N-1:0]      gnt;
  logic [W-1:0]      prod_out;
  logic              prod_valid;
  logic [1:0]        prod_id;
  logic              prod_last;
  logic              busy;
  logic              overrun;

  mac_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .QUANT_BITS(Q), .MAX_BEATS(MAXB)) dut (
    .clock(clock), .reset(reset), .req(req), .last(last), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .prod_out(prod_out), .prod_valid(prod_valid), .prod_id(prod_id),
    .prod_last(prod_last), .busy(busy), .overrun(overrun));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pv_seen = 0;

  // Behavioural model state: burst ownership, beat count, and a product scheduled for the next edge.
  bit          m_burst;
  int          m_owner, m_ptr, m_cnt;
  bit          m_ovr;
  logic [N-1:0] m_gnt;
  bit          s_v;
  logic [W-1:0] s_out;
  int          s_id;
  bit          s_last;
  bit          e_pv;
  logic [W-1:0] e_out;
  int          e_id;
  bit          e_last;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [W-1:0] dq(logic [W-1:0] a, logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> Q;
    return p[W-1:0];
  endfunction

  task automatic model_reset();
    m_burst = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_ovr = 0; m_gnt = '0;
    s_v = 0; s_out = '0; s_id = 0; s_last = 0;
    e_pv = 0; e_out = '0; e_id = 0; e_last = 0;
  endtask

  task automatic model_edge();
    bit found;
    e_pv = s_v;
    if (s_v) begin e_out = s_out; e_id = s_id; e_last = s_last; end
    s_v = 0;
    if (m_burst) begin
      if (req[m_owner]) begin
        m_cnt++;
        s_v = 1;
        s_out = dq(a_in[m_owner], b_in[m_owner]);
        s_id = m_owner;
        s_last = last[m_owner] || (m_cnt == MAXB);
        if (s_last) begin
          if (!last[m_owner]) m_ovr = 1;
          m_burst = 0; m_gnt = '0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
        end
      end
    end else if (req != 0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && req[(m_ptr + i) % N]) begin m_owner = (m_ptr + i) % N; found = 1; end
      end
      m_burst = 1;
      m_gnt = N'(1) << m_owner;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    if (prod_valid) pv_seen++;
    chk("m_gnt", 64'(gnt), 64'(m_gnt));
    chk("m_pvalid", 64'(prod_valid), 64'(e_pv));
    chk("m_pout", 64'(prod_out), 64'(e_out));
    chk("m_pid", 64'(prod_id), 64'(e_id));
    chk("m_plast", 64'(prod_last), 64'(e_last));
    chk("m_busy", 64'(busy), 64'(m_burst || s_v || e_pv));
    chk("m_overrun", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_pvalid", 64'(prod_valid), 64'd0);
    chk("rst_pout", 64'(prod_out), 64'd0);
    chk("rst_pid", 64'(prod_id), 64'd0);
    chk("rst_plast", 64'(prod_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [N-1:0] gnt;
    logic         pv;
    logic [W-1:0] out;
    logic         pl;
  } vec_t;

  vec_t vt[9];
  int grants[$];
  int ids[$];
  logic [N-1:0] prev_gnt;
  int sep_bad, base, n_prod, n_last, last_pos, g1_low;
  bit long_mode;

  initial begin
    // Directed table: two-beat burst of 3s, then a single negative beat (-2048*5 >> 10 = -10).
    vt[0] = '{4'b0001, 4'b0000, 32'h400, 32'd3, 4'b0001, 1'b0, 32'd0, 1'b0};
    vt[1] = '{4'b0001, 4'b0000, 32'h400, 32'd3, 4'b0001, 1'b0, 32'd0, 1'b0};
    vt[2] = '{4'b0001, 4'b0001, 32'h400, 32'd3, 4'b0000, 1'b1, 32'd3, 1'b0};
    vt[3] = '{4'b0000, 4'b0000, 32'h0,   32'd0, 4'b0000, 1'b1, 32'd3, 1'b1};
    vt[4] = '{4'b0000, 4'b0000, 32'h0,   32'd0, 4'b0000, 1'b0, 32'd3, 1'b1};
    vt[5] = '{4'b0001, 4'b0001, 32'hFFFFF800, 32'd5, 4'b0001, 1'b0, 32'd3, 1'b1};
    vt[6] = '{4'b0001, 4'b0001, 32'hFFFFF800, 32'd5, 4'b0000, 1'b0, 32'd3, 1'b1};
    vt[7] = '{4'b0000, 4'b0000, 32'h0,   32'd0, 4'b0000, 1'b1, 32'hFFFFFFF6, 1'b1};
    vt[8] = '{4'b0000, 4'b0000, 32'h0,   32'd0, 4'b0000, 1'b0, 32'hFFFFFFF6, 1'b1};

    reset = 1'b0; req = '0; last = '0; a_in = '0; b_in = '0;
    #2;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      req = vt[i].req; last = vt[i].last; a_in = '0; b_in = '0;
      a_in[0] = vt[i].a; b_in[0] = vt[i].b;
      tick();
      chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vt[i].gnt));
      chk($sformatf("vec%0d_pvalid", i), 64'(prod_valid), 64'(vt[i].pv));
      chk($sformatf("vec%0d_pout", i), 64'(prod_out), 64'(vt[i].out));
      chk($sformatf("vec%0d_plast", i), 64'(prod_last), 64'(vt[i].pl));
      if (vt[i].pv) chk($sformatf("vec%0d_pid", i), 64'(prod_id), 64'd0);
    end

    // All four request single-beat bursts: round-robin order with idle gaps.
    do_reset();
    req = 4'b1111; last = 4'b1111;
    for (int i = 0; i < N; i++) begin a_in[i] = W'((i + 1) << Q); b_in[i] = W'(i + 2); end
    prev_gnt = '0; sep_bad = 0;
    grants.delete(); ids.delete();
    for (int c = 0; c < 40 && ids.size() < 4; c++) begin
      tick();
      if (gnt != 0 && prev_gnt == 0)
        for (int k = 0; k < N; k++) if (gnt[k]) grants.push_back(k);
      if (gnt != 0 && prev_gnt != 0 && gnt != prev_gnt) sep_bad++;
      if (prod_valid) ids.push_back(int'(prod_id));
      prev_gnt = gnt;
    end
    chk("rr_nprod", 64'(ids.size()), 64'd4);
    chk("rr_gap", 64'(sep_bad), 64'd0);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i));
    for (int i = 0; i < ids.size(); i++) chk($sformatf("rr_id%0d", i), 64'(ids[i]), 64'(i));
    req = '0; last = '0;
    repeat (4) tick();

    // Requester 2 streams beats without last: forced termination at MAX_BEATS.
    do_reset();
    req = 4'b0100; last = '0; a_in[2] = W'(7 << Q); b_in[2] = 32'd1;
    n_prod = 0; n_last = 0; last_pos = 0;
    tick();
    chk("ovr_grant", 64'(gnt), 64'b0100);
    for (int i = 0; i < MAXB + 1; i++) begin
      tick();
      if (prod_valid) begin
        n_prod++;
        if (prod_last) begin n_last++; last_pos = n_prod; end
      end
      if (i == MAXB - 1) chk("ovr_gnt_drop", 64'(gnt), 64'd0);
    end
    chk("ovr_regrant", 64'(gnt), 64'b0100);
    chk("ovr_flag", 64'(overrun), 64'd1);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (prod_valid) n_prod++;
    end
    chk("ovr_nprod", 64'(n_prod), 64'(MAXB));
    chk("ovr_nlast", 64'(n_last), 64'd1);
    chk("ovr_lastpos", 64'(last_pos), 64'(MAXB));

    // Reset during a burst after a beat was accepted: nothing escapes, pointer restarts.
    do_reset();
    req = 4'b0010; last = 4'b0010;
    repeat (2) tick();
    req = '0; last = '0;
    repeat (2) tick();
    req = 4'b0100;
    tick();
    chk("mid_grant2", 64'(gnt), 64'b0100);
    tick();
    do_reset();
    req = '0;
    base = pv_seen;
    repeat (4) tick();
    chk("mid_no_prod", 64'(pv_seen - base), 64'd0);
    req = 4'b1111; last = 4'b1111;
    tick();
    chk("mid_next_gnt", 64'(gnt), 64'b0001);
    req = '0; last = '0;
    repeat (4) tick();

    // Requester 1 stalls mid-burst: grant held, exactly two products.
    do_reset();
    base = pv_seen; g1_low = 0;
    req = 4'b0010; last = '0; a_in[1] = 32'hFFFFF000; b_in[1] = 32'd9;
    tick();
    if (!gnt[1]) g1_low++;
    tick();
    if (!gnt[1]) g1_low++;
    req = '0;
    tick();
    if (!gnt[1]) g1_low++;
    req = 4'b0010; last = 4'b0010;
    tick();
    req = '0; last = '0;
    repeat (3) tick();
    chk("stall_gnt_held", 64'(g1_low), 64'd0);
    chk("stall_nprod", 64'(pv_seen - base), 64'd2);

    // Random traffic checked against the model, with occasional resets and long-burst phases.
    do_reset();
    long_mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) long_mode = ($urandom_range(0, 2) == 0);
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        last[k] = long_mode ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
        a_in[k] = ($urandom_range(0, 1) == 0) ? $urandom : W'($signed($urandom_range(0, 8191)) - 4096);
        b_in[k] = ($urandom_range(0, 1) == 0) ? $urandom : W'($signed($urandom_range(0, 255)) - 128);
      end
      tick();
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
